// File: rtl/apb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : apb_rr_arbiter
// Description : Round-robin arbiter sharing one APB4 requester port between
//               NoMasters upstream APB4 requesters. Optional ACCESS timeout
//               enabled by defining APB_RR_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_rr_arbiter #(
  parameter int NoMasters     = 4,
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 256,
  localparam int STRB_W = DataWidth / 8,
  localparam int REQ_W  = AddrWidth + 3 + 3 + DataWidth + STRB_W,
  localparam int RESP_W = DataWidth + 2,
  localparam int IDX_W  = $clog2(NoMasters)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NoMasters*REQ_W-1:0]  mst_req_i,
  output logic [NoMasters*RESP_W-1:0] mst_resp_o,
  output logic [REQ_W-1:0]            slv_req_o,
  input  logic [RESP_W-1:0]           slv_resp_i,
  output logic [IDX_W-1:0]            gnt_idx_o,
  output logic                        busy_o
);

  typedef struct packed {
    logic [AddrWidth-1:0] paddr;
    logic [2:0]           pprot;
    logic                 psel;
    logic                 penable;
    logic                 pwrite;
    logic [DataWidth-1:0] pwdata;
    logic [STRB_W-1:0]    pstrb;
  } apb_req_t;

  typedef struct packed {
    logic                 pready;
    logic [DataWidth-1:0] prdata;
    logic                 pslverr;
  } apb_resp_t;

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_SETUP  = 2'd1;
  localparam logic [1:0] c_ACCESS = 2'd2;
  localparam logic [1:0] c_RESP   = 2'd3;

  logic [1:0]           r_state;
  logic [IDX_W-1:0]     r_rr_ptr;
  logic [IDX_W-1:0]     r_gnt;
  apb_req_t             r_req;
  logic [DataWidth-1:0] r_rdata;
  logic                 r_slverr;

  apb_req_t             w_mst_req [NoMasters];
  logic [NoMasters-1:0] w_cand;
  logic [NoMasters-1:0] w_unused_penable;
  apb_resp_t            w_slv_resp;
  apb_req_t             w_slv_req;
  logic                 w_found;
  logic [IDX_W-1:0]     w_pick;
  logic [IDX_W-1:0]     w_pick_next;
  logic [IDX_W-1:0]     w_j;
  logic                 w_timeout;

  assign w_slv_resp = slv_resp_i;

  // Upstream penable is irrelevant: any psel makes a master a candidate.
  for (genvar gi = 0; gi < NoMasters; gi++) begin : g_unpack
    assign w_mst_req[gi]        = mst_req_i[gi*REQ_W +: REQ_W];
    assign w_cand[gi]           = w_mst_req[gi].psel;
    assign w_unused_penable[gi] = w_mst_req[gi].penable;
  end

  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_j     = '0;
    for (int k = 0; k < NoMasters; k++) begin
      w_j = IDX_W'((int'(r_rr_ptr) + k) % NoMasters);
      if (!w_found && w_cand[w_j]) begin
        w_found = 1'b1;
        w_pick  = w_j;
      end
    end
  end

  assign w_pick_next = (w_pick == IDX_W'(NoMasters - 1)) ? '0 : w_pick + 1'b1;

`ifdef APB_RR_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TimeoutCycles);

  logic [CNT_W-1:0] r_tmo_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tmo_cnt <= '0;
    end else if (r_state != c_ACCESS) begin
      r_tmo_cnt <= '0;
    end else if (!w_slv_resp.pready) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == c_ACCESS) && !w_slv_resp.pready &&
                     (r_tmo_cnt == CNT_W'(TimeoutCycles - 1));
`else
  logic [31:0] w_unused_tmo;
  assign w_unused_tmo = 32'(TimeoutCycles);
  assign w_timeout    = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= c_IDLE;
      r_rr_ptr <= '0;
      r_gnt    <= '0;
      r_req    <= '0;
      r_rdata  <= '0;
      r_slverr <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_found) begin
            r_req    <= w_mst_req[w_pick];
            r_gnt    <= w_pick;
            r_rr_ptr <= w_pick_next;
            r_state  <= c_SETUP;
          end
        end
        c_SETUP: r_state <= c_ACCESS;
        c_ACCESS: begin
          // A real pready wins over a timeout in the same cycle.
          if (w_slv_resp.pready) begin
            r_rdata  <= w_slv_resp.prdata;
            r_slverr <= w_slv_resp.pslverr;
            r_state  <= c_RESP;
          end else if (w_timeout) begin
            r_rdata  <= '0;
            r_slverr <= 1'b1;
            r_state  <= c_RESP;
          end
        end
        c_RESP:  r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

  always_comb begin
    w_slv_req = '0;
    if (r_state == c_SETUP || r_state == c_ACCESS) begin
      w_slv_req         = r_req;
      w_slv_req.psel    = 1'b1;
      w_slv_req.penable = (r_state == c_ACCESS);
    end
  end

  assign slv_req_o = w_slv_req;

  for (genvar gi = 0; gi < NoMasters; gi++) begin : g_resp
    assign mst_resp_o[gi*RESP_W +: RESP_W] =
      (r_state == c_RESP && r_gnt == IDX_W'(gi)) ? {1'b1, r_rdata, r_slverr} : '0;
  end

  assign gnt_idx_o = r_gnt;
  assign busy_o    = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_apb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_rr_arbiter
// Description : Scoreboard bench for apb_rr_arbiter (4 masters, 32-bit bus).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_rr_arbiter;

  localparam int NM = 4;
  localparam int RW = 74;
  localparam int SW = 34;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [RW-1:0]    mreq [NM];
  logic [NM*RW-1:0] mst_req;
  logic [NM*SW-1:0] mst_resp;
  logic [RW-1:0]    slv_req;
  logic [SW-1:0]    slv_resp;
  logic [1:0]       gnt;
  logic             busy;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  assign mst_req = {mreq[3], mreq[2], mreq[1], mreq[0]};

  // Slave model: pready after slv_wait ACCESS cycles; reads return 0x10 + paddr/4.
  int   slv_wait = 0;
  bit   slv_hang = 1'b0;
  bit   slv_err  = 1'b0;
  int   acc_cnt  = 0;
  logic slv_pready;

  assign slv_pready = slv_req[38] & slv_req[37] & !slv_hang & (acc_cnt >= slv_wait);
  assign slv_resp   = {slv_pready, slv_req[36] ? 32'h0 : 32'h10 + {2'b00, slv_req[73:44]}, slv_err};

  always @(posedge clk)
    acc_cnt <= (slv_req[38] && slv_req[37] && !slv_pready) ? acc_cnt + 1 : 0;

  apb_rr_arbiter #(
    .NoMasters    (4),
    .AddrWidth    (32),
    .DataWidth    (32),
    .TimeoutCycles(4)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .mst_req_i (mst_req),
    .mst_resp_o(mst_resp),
    .slv_req_o (slv_req),
    .slv_resp_i(slv_resp),
    .gnt_idx_o (gnt),
    .busy_o    (busy)
  );

  function automatic logic [RW-1:0] mk(input logic [31:0] addr, input logic wr,
                                       input logic [31:0] data, input logic sel,
                                       input logic en);
    return {addr, 3'b000, sel, en, wr, data, 4'hF};
  endfunction

  function automatic logic pr(input int m);
    return mst_resp[m*SW + 33];
  endfunction

  task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic apb_xfer(input int m, input logic [31:0] addr, input logic wr,
                          input logic [31:0] data, input bit keep);
    int cyc;
    @(posedge clk); #1;
    mreq[m] = mk(addr, wr, data, 1'b1, 1'b0);
    @(posedge clk); #1;
    mreq[m][37] = 1'b1;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (pr(m)) break;
      cyc++;
      if (cyc > 64) begin
        n_vec++;
        n_err++;
        $display("FAIL xfer_bound m%0d: pready=0 after %0d cycles, expected pready=1", m, cyc);
        break;
      end
    end
    if (!keep) begin
      @(posedge clk); #1;
      mreq[m] = '0;
    end
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: every upstream pready pops one expected response.
  logic [SW-1:0] mon_r;
  exp_t          mon_e;
  always @(negedge clk) begin
    for (int i = 0; i < NM; i++) begin
      mon_r = mst_resp[i*SW +: SW];
      n_vec++;
      if (mon_r[33]) begin
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL resp_unexpected: master %0d got pready with prdata=%0h, expected no response", i, mon_r[32:1]);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.idx != i || mon_e.rdata !== mon_r[32:1] || mon_e.err !== mon_r[0]) begin
            n_err++;
            $display("FAIL resp: got master=%0d prdata=%0h pslverr=%0b, expected master=%0d prdata=%0h pslverr=%0b",
                     i, mon_r[32:1], mon_r[0], mon_e.idx, mon_e.rdata, mon_e.err);
          end
        end
      end else if (mon_r !== '0) begin
        n_err++;
        $display("FAIL resp_quiet: master %0d got %0h, expected 0", i, mon_r);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1ms, expected completion");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  got;
    logic [RW-1:0] snap;
    for (int i = 0; i < NM; i++) mreq[i] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_slv_req", 136'(slv_req), 136'h0);
    chk("rst_mst_resp", 136'(mst_resp), 136'h0);
    chk("rst_busy", 136'(busy), 136'h0);
    chk("rst_gnt", 136'(gnt), 136'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // T1: single write from master 0, latency check
    exp_q.push_back('{0, 32'h0, 1'b0});
    @(posedge clk); #1;
    mreq[0] = mk(32'h100, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
    @(negedge clk);
    chk("t1_idle_busy", 136'(busy), 136'h0);
    @(negedge clk);
    chk("t1_setup", 136'(slv_req), 136'(mk(32'h100, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0)));
    chk("t1_busy", 136'(busy), 136'h1);
    @(posedge clk); #1;
    mreq[0][37] = 1'b1;
    @(negedge clk);
    chk("t1_access", 136'(slv_req), 136'(mk(32'h100, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1)));
    @(negedge clk);
    chk("t1_resp_pready", 136'(pr(0)), 136'h1);
    chk("t1_resp_psel", 136'(slv_req[38]), 136'h0);
    @(posedge clk); #1;
    mreq[0] = '0;

    // T2: all four masters read at once after reset -> grants 0,1,2,3
    rst_pulse();
    for (int i = 0; i < NM; i++) exp_q.push_back('{i, 32'h10 + i, 1'b0});
    fork
      apb_xfer(0, 32'h0, 1'b0, 32'h0, 1'b0);
      apb_xfer(1, 32'h4, 1'b0, 32'h0, 1'b0);
      apb_xfer(2, 32'h8, 1'b0, 32'h0, 1'b0);
      apb_xfer(3, 32'hC, 1'b0, 32'h0, 1'b0);
    join

    // T3: master 2 moves rr_ptr to 3; then 0 once and 2 continuously -> 0, 2, 2
    exp_q.push_back('{2, 32'h12, 1'b0});
    apb_xfer(2, 32'h8, 1'b0, 32'h0, 1'b0);
    exp_q.push_back('{0, 32'h10, 1'b0});
    exp_q.push_back('{2, 32'h13, 1'b0});
    exp_q.push_back('{2, 32'h14, 1'b0});
    fork
      apb_xfer(0, 32'h0, 1'b0, 32'h0, 1'b0);
      begin
        apb_xfer(2, 32'hC, 1'b0, 32'h0, 1'b1);
        apb_xfer(2, 32'h10, 1'b0, 32'h0, 1'b0);
      end
    join

    // T4: slave waits 7 cycles then errors; request must stay stable
    slv_wait = 7;
    slv_err  = 1'b1;
    exp_q.push_back('{1, 32'h0, 1'b1});
    fork
      apb_xfer(1, 32'h40, 1'b1, 32'h12345678, 1'b0);
      begin
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
          @(negedge clk);
          if (slv_req[38] && slv_req[37]) got = 1'b1;
        end
        chk("t4_access_seen", 136'(got), 136'h1);
        snap = slv_req;
        n = 1;
        while (n < 40) begin
          @(negedge clk);
          if (!(slv_req[38] && slv_req[37])) break;
          chk("t4_stable", 136'(slv_req), 136'(snap));
          n++;
          if (n == 3) mreq[1][35:4] = 32'hFFFF0000;
        end
        chk("t4_access_cycles", 136'(n), 136'd8);
      end
    join
    slv_wait = 0;
    slv_err  = 1'b0;

    // T5: reset during ACCESS, then rr_ptr must restart at 0
    slv_hang = 1'b1;
    @(posedge clk); #1;
    mreq[1] = mk(32'h80, 1'b0, 32'h0, 1'b1, 1'b0);
    @(posedge clk); #1;
    mreq[1][37] = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (slv_req[38] && slv_req[37]) got = 1'b1;
    end
    chk("t5_in_access", 136'(got), 136'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_slv_req", 136'(slv_req), 136'h0);
    chk("t5_rst_busy", 136'(busy), 136'h0);
    chk("t5_rst_gnt", 136'(gnt), 136'h0);
    mreq[1]  = '0;
    slv_hang = 1'b0;
    @(negedge clk);
    chk("t5_no_resp", 136'(mst_resp), 136'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back('{1, 32'h11, 1'b0});
    exp_q.push_back('{3, 32'h13, 1'b0});
    fork
      apb_xfer(1, 32'h4, 1'b0, 32'h0, 1'b0);
      apb_xfer(3, 32'hC, 1'b0, 32'h0, 1'b0);
    join

    // T6: slave never ready
    slv_hang = 1'b1;
`ifdef APB_RR_ARB_TIMEOUT_EN
    exp_q.push_back('{0, 32'h0, 1'b1});
    fork
      apb_xfer(0, 32'h20, 1'b0, 32'h0, 1'b0);
      begin
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
          @(negedge clk);
          if (slv_req[38] && slv_req[37]) got = 1'b1;
        end
        n = 1;
        while (n < 40) begin
          @(negedge clk);
          if (!(slv_req[38] && slv_req[37])) break;
          n++;
        end
        chk("t6_timeout_cycles", 136'(n), 136'd4);
      end
    join
    slv_hang = 1'b0;
`else
    @(posedge clk); #1;
    mreq[0] = mk(32'h20, 1'b0, 32'h0, 1'b1, 1'b0);
    @(posedge clk); #1;
    mreq[0][37] = 1'b1;
    repeat (1000) @(negedge clk);
    chk("t6_still_busy", 136'(busy), 136'h1);
    chk("t6_still_access", 136'(slv_req[38:37]), 136'h3);
    #2;
    rst = 1'b1;
    mreq[0]  = '0;
    slv_hang = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
`endif

    repeat (5) @(negedge clk);
    chk("queue_empty", 136'(exp_q.size()), 136'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
